arbitro_rr4: RTL
================

Name: arbitro_rr4

Overview:
- Round-robin arbiter/scheduler sharing one 8-bit data/valid channel among four byte FIFOs.
- Sits between the four input FIFOs and the mux/serializer side of the link, in the clk2f domain.
- Pops the granted FIFO and forwards bytes in bursts of up to MAX_BURST, then rotates the grant.
- Throttles on downstream almost_full.

Parameters:
- DATA_W, 8, width of data path
- MAX_BURST, 4, max bytes forwarded per grant before rotation (1..15)

Ports:
- clk2f  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high reset
- data_in_0..data_in_3  input  DATA_W each  show-ahead FIFO head data (valid when matching empty_x=0)
- empty_0..empty_3  input  1 each  FIFO x empty
- pop_0..pop_3  output  1 each  consume head of FIFO x this cycle
- almost_full_out  input  1  downstream cannot accept more than the in-flight byte
- data_out  output  DATA_W  registered forwarded byte
- valid_out  output  1  data_out valid this cycle
- grant_id  output  2  index of currently/last granted FIFO
- busy  output  1  high in XFER or PAUSE

Behaviour:
- Reset (async, reset=1):
  - state=IDLE; all pop_x=0; data_out=0; valid_out=0; grant_id=3 (so FIFO 0 is checked first); burst_cnt=0; busy=0.
- Output path:
  - pop_x is combinational from state, grant and inputs.
  - data_out/valid_out are registered: a byte popped in cycle N appears with valid_out=1 in cycle N+1.
  - valid_out=0 in every cycle after a cycle with no pop; data_out is then held at its last value.
- At most one pop_x is high per cycle. pop_x is never high while empty_x=1 or almost_full_out=1.
- Priority search: starts at (grant_id+1) mod 4 and wraps; the first non-empty FIFO wins.
- IDLE:
  - If any empty_x=0 and almost_full_out=0: load winner into grant_id, burst_cnt=0, go to XFER.
  - No pop in this cycle; arbitration costs one cycle.
- XFER:
  - If empty_g=0 and almost_full_out=0: pop_g=1, burst_cnt++.
  - If burst_cnt reaches MAX_BURST (after increment), or empty_g=1: go to ARB.
  - If almost_full_out=1: go to PAUSE; no pop.
- PAUSE:
  - No pops; grant and burst_cnt are held.
  - When almost_full_out=0: return to XFER.
  - If empty_g became 1 meanwhile: go to ARB instead.
- ARB:
  - No pop. Search from (grant_id+1).
  - If a non-empty FIFO is found and almost_full_out=0: new grant_id, burst_cnt=0, go to XFER.
  - Otherwise go to IDLE.
  - The same FIFO may be re-granted only if all others are empty.
- Timing: back-to-back burst from one FIFO gives MAX_BURST consecutive valid_out cycles. Rotation inserts exactly 1 idle cycle.
- Simultaneous events:
  - almost_full_out rising in the same cycle as the last burst byte: that pop is suppressed; go to PAUSE, burst_cnt unchanged.
  - empty_g and almost_full_out both high in XFER: go to ARB (empty takes precedence).
- burst_cnt is 4 bits, saturating at MAX_BURST; no wrap.
- Reset mid-burst: pops drop immediately (async). The in-flight registered byte is discarded (valid_out=0). FIFO contents are untouched.
- Starvation bound: any non-empty FIFO is granted within 3*(MAX_BURST+1)+1 cycles while almost_full_out=0.

Test Plan:
- Reset then FIFO0 holds 0x11,0x22,0x33, others empty → IDLE, 1 cycle later pop_0 for 3 cycles; valid_out on cycles 3-5 with 0x11,0x22,0x33; ARB; IDLE; grant_id=0.
- All four FIFOs hold 6 bytes each, MAX_BURST=4 → grants 0,1,2,3,0,1,2,3 in order. Each first burst is 4 pops, the second is 2. One idle cycle between bursts. 24 bytes out in FIFO order.
- FIFO1 streaming, almost_full_out asserted after the 2nd pop for 3 cycles → pops stop the same cycle, state PAUSE, grant_id=1, burst_cnt=2. Resume completes 2 more bytes, then rotates.
- FIFO2 empties mid-burst (after 1 byte) while FIFO3 is non-empty → ARB next cycle, grant_id=3; no pop_2 when empty_2=1.
- Reset asserted asynchronously mid-burst on FIFO0 → pop_0, valid_out, busy go to 0 immediately, grant_id=3. After release, FIFO0 is regranted first.
- Only FIFO0 non-empty with 10 bytes, MAX_BURST=4 → bursts of 4,4,2 with re-grant to 0; one idle cycle between bursts.

Source files
------------

// File: rtl/arbitro_rr4.sv
// arbitro_rr4: round-robin scheduler that shares one byte channel among four
// show-ahead FIFOs. Each grant forwards up to MAX_BURST bytes, then the grant
// rotates. Downstream almost_full pauses the transfer without losing the grant.
module arbitro_rr4 #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic [DATA_W-1:0] data_in_2,
  input  logic [DATA_W-1:0] data_in_3,
  input  logic              empty_0,
  input  logic              empty_1,
  input  logic              empty_2,
  input  logic              empty_3,
  output logic              pop_0,
  output logic              pop_1,
  output logic              pop_2,
  output logic              pop_3,
  input  logic              almost_full_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [1:0]        grant_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_PAUSE = 2'd2,
    S_ARB   = 2'd3
  } state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  state_t            r_state;
  logic [1:0]        r_grant;
  logic [3:0]        r_burst_cnt;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  logic [3:0]        w_empty;
  logic [DATA_W-1:0] w_data [4];
  logic              w_any_ready;
  logic [1:0]        w_winner;
  logic              w_empty_g;
  logic              w_pop_en;
  logic [3:0]        w_burst_inc;
  logic [3:0]        w_pop;

  assign w_empty     = {empty_3, empty_2, empty_1, empty_0};
  assign w_data[0]   = data_in_0;
  assign w_data[1]   = data_in_1;
  assign w_data[2]   = data_in_2;
  assign w_data[3]   = data_in_3;
  assign w_any_ready = ~&w_empty;
  assign w_empty_g   = w_empty[r_grant];

  // Only the granted FIFO is popped, and only while it has data and downstream has room
  assign w_pop_en    = (r_state == S_XFER) && !w_empty_g && !almost_full_out;

  // Burst counter saturates instead of wrapping
  assign w_burst_inc = (r_burst_cnt >= BURST_MAX) ? r_burst_cnt : r_burst_cnt + 4'd1;

  // Rotating priority: scan offsets 4..1 so the nearest non-empty FIFO after the
  // current grant wins; offset 4 is the current grant itself, chosen only when alone
  always_comb begin
    w_winner = r_grant;
    for (int i = 4; i >= 1; i--) begin
      if (!w_empty[r_grant + 2'(i)]) begin
        w_winner = r_grant + 2'(i);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pop
      assign w_pop[gi] = w_pop_en && (r_grant == 2'(gi));
    end
  endgenerate

  assign pop_0     = w_pop[0];
  assign pop_1     = w_pop[1];
  assign pop_2     = w_pop[2];
  assign pop_3     = w_pop[3];
  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign grant_id  = r_grant;
  assign busy      = (r_state == S_XFER) || (r_state == S_PAUSE);

  // Scheduler FSM plus the output byte register; a popped byte appears next cycle
  always_ff @(posedge clk2f or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_grant     <= 2'd3;
      r_burst_cnt <= 4'd0;
      r_data      <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= w_pop_en;
      if (w_pop_en) begin
        r_data <= w_data[r_grant];
      end

      case (r_state)
        S_IDLE: begin
          if (w_any_ready && !almost_full_out) begin
            r_grant     <= w_winner;
            r_burst_cnt <= 4'd0;
            r_state     <= S_XFER;
          end
        end

        S_XFER: begin
          // An empty grantee ends the burst even if downstream is also full
          if (w_empty_g) begin
            r_state <= S_ARB;
          end else if (almost_full_out) begin
            r_state <= S_PAUSE;
          end else begin
            r_burst_cnt <= w_burst_inc;
            if (w_burst_inc >= BURST_MAX) begin
              r_state <= S_ARB;
            end
          end
        end

        S_PAUSE: begin
          if (!almost_full_out) begin
            r_state <= w_empty_g ? S_ARB : S_XFER;
          end
        end

        S_ARB: begin
          if (w_any_ready && !almost_full_out) begin
            r_grant     <= w_winner;
            r_burst_cnt <= 4'd0;
            r_state     <= S_XFER;
          end else begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
